cord_pair_serializer: RTL and testbench

// - Downstream stage of the multiple-constant-rotation core. Captures each rotated

---
 rtl/cord_pkg.sv | 24 ++
 rtl/cord_pair_fifo.sv | 64 ++++++
 rtl/cord_pair_serializer.sv | 131 +++++++++++++
 tb/tb_cord_pair_serializer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cord_pkg.sv
// Shared constants for the rotation core and its pair serializer.
// Output FSM state encoding lives here so both sides agree on it.
package cord_pkg;

  localparam int CORD_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND1 = 2'd1;
  localparam logic [1:0] ST_SEND2 = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SEND1 = ST_SEND1,
    SEND2 = ST_SEND2
  } ser_state_e;

  function automatic logic [2*CORD_W-1:0] pack_pair(
    input logic [CORD_W-1:0] c1,
    input logic [CORD_W-1:0] c2
  );
    return {c1, c2};
  endfunction

endpackage

// File: rtl/cord_pair_fifo.sv
// Pair FIFO: DEPTH entries of DW bits, wrap-around pointers and a
// registered occupancy count from which full/empty are decoded.
module cord_pair_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic [AW:0]   level_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    level_d = level_q;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/cord_pair_serializer.sv
// Buffers rotated coordinate pairs and streams them as two bytes,
// cord1 then cord2, with back-pressure and a sticky drop flag.
module cord_pair_serializer
  import cord_pkg::*;
#(
  parameter int W     = CORD_W,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] cord1,
  input  logic [W-1:0] cord2,
  output logic         in_ready,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         clr_ovf,
  output logic         ovf,
  output logic [AW:0]  level
);

  ser_state_e     state_q;
  logic           out_valid_q;
  logic [W-1:0]   out_data_q;
  logic           out_last_q;
  logic [W-1:0]   hold_q;
  logic           ovf_q;
  logic           ovf_d;

  logic           push;
  logic           load;
  logic           drop;
  logic           f_full;
  logic           f_empty;
  logic [2*W-1:0] f_head;

  assign in_ready = !f_full;
  assign push     = in_valid && !f_full;
  assign drop     = in_valid && f_full;

  // The head is popped only when it is moved into the output registers.
  assign load = !f_empty &&
                ((state_q == IDLE) ||
                 (state_q == SEND2 && out_ready));

  cord_pair_fifo #(
    .DW    (2*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (load),
    .wdata_i ({cord1, cord2}),
    .rdata_o (f_head),
    .full_o  (f_full),
    .empty_o (f_empty),
    .level_o (level)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      hold_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            state_q     <= SEND1;
            out_valid_q <= 1'b1;
            out_data_q  <= f_head[2*W-1:W];
            hold_q      <= f_head[W-1:0];
            out_last_q  <= 1'b0;
          end
        end
        SEND1: begin
          if (out_ready) begin
            state_q    <= SEND2;
            out_data_q <= hold_q;
            out_last_q <= 1'b1;
          end
        end
        SEND2: begin
          if (out_ready) begin
            if (load) begin
              state_q    <= SEND1;
              out_data_q <= f_head[2*W-1:W];
              hold_q     <= f_head[W-1:0];
              out_last_q <= 1'b0;
            end else begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign ovf       = ovf_q;

  logic unused_pkg;
  assign unused_pkg = ^pack_pair(cord1, cord2);

endmodule

// File: tb/tb_cord_pair_serializer.sv
// Scoreboard bench for cord_pair_serializer: accepted pairs queue
// expected bytes, a negedge monitor checks every accepted output byte.
module tb_cord_pair_serializer;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  cord1;
  logic [W-1:0]  cord2;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          clr_ovf;
  logic          ovf;
  logic [AW:0]   level;

  cord_pair_serializer #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .cord1     (cord1),
    .cord2     (cord2),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .clr_ovf   (clr_ovf),
    .ovf       (ovf),
    .level     (level)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [W:0] exp_q [$];
  logic bub_pend = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      bub_pend = 1'b0;
    end else begin
      if (bub_pend) check("no_bubble", out_valid, 1);
      bub_pend = 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, cord1});
        exp_q.push_back({1'b1, cord2});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_byte: got %0h expected none", out_data);
        end else begin
          check("byte", {out_last, out_data}, exp_q.pop_front());
        end
        if (out_last && level != 0) bub_pend = 1'b1;
      end
    end
  end

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    cord1    = a;
    cord2    = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((out_valid || level != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", (n < 100), 1);
    check("drain_level", level, 0);
  endtask

  initial begin
    logic [15:0] pat;
    int cyc;
    int stale;
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; cord1 = '0; cord2 = '0;
    out_ready = 1'b1; clr_ovf = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single pair, latency
    push_pair(8'h3A, 8'hC5);
    check("lat_level", level, 1);
    check("lat_valid_k", out_valid, 0);
    @(posedge clk); #1;
    check("lat_valid_k1", out_valid, 1);
    check("b1_data", out_data, 8'h3A);
    check("b1_last", out_last, 0);
    @(posedge clk); #1;
    check("b2_data", out_data, 8'hC5);
    check("b2_last", out_last, 1);
    @(posedge clk); #1;
    check("idle_valid", out_valid, 0);

    // back-pressure
    out_ready = 1'b0;
    push_pair(8'h3A, 8'hC5);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_data", {out_valid, out_last, out_data}, {2'b10, 8'h3A});
      @(posedge clk); #1;
    end
    check("bp_hold", {out_valid, out_last, out_data}, {2'b10, 8'h3A});
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel", {out_valid, out_last, out_data}, {2'b11, 8'hC5});
    @(posedge clk); #1;
    check("bp_idle", out_valid, 0);

    // fill and overflow
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_pair(8'h50 + 8'(i), 8'hA0 + 8'(i));
    check("full_level", level, 4);
    check("full_in_ready", in_ready, 0);
    check("full_ovf_pre", ovf, 0);
    push_pair(8'hEE, 8'hEF);
    check("ovf_set", ovf, 1);
    check("ovf_level", level, 4);
    check("ovf_in_ready", in_ready, 0);
    clr_ovf = 1'b1;
    push_pair(8'hDD, 8'hDE);
    clr_ovf = 1'b0;
    check("ovf_set_wins", ovf, 1);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    check("ovf_clr", ovf, 0);
    drain();

    // wrap-around with patterned back-pressure
    pat = 16'b1011_0010_1110_0110;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      cord1 = 8'h10 + 8'(i);
      cord2 = 8'hF0 - 8'(i);
      acc = 1'b0;
      while (!acc && cyc < 500) begin
        out_ready = pat[cyc % 16];
        acc       = in_ready;
        in_valid  = in_ready;
        cyc++;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
    end
    check("wrap_budget", (cyc < 500), 1);
    drain();
    check("wrap_no_ovf", ovf, 0);

    // simultaneous push and pop at level 2
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_pair(8'h61 + 8'(i), 8'h91 + 8'(i));
    check("pp_level_pre", level, 2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("pp_send2", out_last, 1);
    check("pp_level_mid", level, 2);
    push_pair(8'h64, 8'h94);
    check("pp_level_post", level, 2);
    drain();

    // reset mid-pair
    out_ready = 1'b0;
    push_pair(8'h71, 8'h81);
    push_pair(8'h72, 8'h82);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("mr_in_send2", {out_valid, out_last}, 2'b11);
    out_ready = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_level", level, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("mr_no_stale", stale, 0);
    push_pair(8'h5A, 8'hA5);
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
